img2col_weight_core: RTL and testbench
======================================

# img2col_weight_core

Weight-reordering engine for the convolution datapath. It reads a kernel's weights from a single-port-read weight BRAM, stored in channel-major order. It then rewrites them sequentially into a downstream weight buffer in img2col (kernel-position-major) order. It sits between the weight BRAM (256×16, 1-cycle read latency) and the two ping-pong weight buffers feeding the PE array.

## Interface
No parameters; widths fixed.
- clock  in  1  single clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- i2c_wgt_start  in  1  level request; sampled in IDLE only.
- i2c_chn_sel  in  1  destination buffer select; latched at start.
- chn_num  in  7  index of the last weight in BRAM, i.e. C·K·K−1; latched at start.
- kernel_size  in  4  K (1..15); latched at start.
- wgt_in  in  16  BRAM read data, valid the cycle after the BRAM samples rd_en/addr.
- i2c_ready  out  1  done flag.
- wgt_rd_addr  out  8  BRAM read address.
- wgt_rd_en  out  1  BRAM read enable.
- wgt_wr_addr  out  8  output-buffer write address.
- wgt_wr_en  out  1  output-buffer write strobe.
- wgt_out  out  16  output-buffer write data.
- chn_sel  out  1  latched i2c_chn_sel, steers the write to a buffer.

## Operation
- Reset: every output 0 and state IDLE. Asserting reset mid-operation aborts the pass immediately; there is no partial-completion flag.
- States: IDLE → READ → DRAIN → DONE → IDLE.
- **IDLE**
  - On i2c_wgt_start=1: latch chn_num (N), kernel_size (K) and chn_sel.
  - Compute KK=K·K (8 bit, ≤225).
  - Clear k=0, addr=0, wr_addr=0; go to READ.
- **READ** (one read per cycle)
  - Drive wgt_rd_en=1 with wgt_rd_addr=addr.
  - Next address: nxt=addr+KK, computed 9 bit.
  - If nxt≤N: addr=nxt.
  - Else if k+1<KK and k+1≤N: k=k+1, addr=k+1.
  - Else the last read has been issued; go to DRAIN.
  - Resulting read order is addr = k + c·KK: outer loop k=0..KK−1, inner loop c=0..C−1.
  - Every address 0..N is read exactly once, including when N+1 is not a multiple of KK.
- **Read/write pipeline**
  - rd_en is delayed through a 2-stage valid pipe.
  - wgt_out is registered from wgt_in.
  - wgt_wr_en=1 at the matching slot; wgt_wr_addr=wr_addr, which then increments.
  - Writes are sequential 0..N with no gaps.
- **DRAIN**: wait until the pipe is empty, then go to DONE.
- **DONE**
  - i2c_ready=1, held while i2c_wgt_start=1.
  - When start=0: ready=0 and go to IDLE.
  - A start still high after ready is not a new request.
- Start is ignored outside IDLE. Inputs changing mid-pass have no effect.
- kernel_size=0: no reads or writes; go straight to DONE.
- chn_sel holds its latched value until the next start.

## Timing
- Start sampled at edge t0. wgt_rd_en is high from t0+1 for exactly N+1 consecutive cycles.
- Per-read latency:
  - Read issued (rd_en/addr valid) in cycle n.
  - BRAM registers at the end of n; wgt_in is valid in n+1.
  - Write (wr_en, wr_addr, wgt_out) is valid in cycle n+2.
- Write phase is N+1 consecutive cycles, 2 cycles behind reads.
- i2c_ready rises the cycle after the last write.
- Total latency from start to ready: N+4 cycles.
- wgt_rd_en and wgt_wr_en are 0 outside their windows. Address outputs may hold their last value.
- Re-arm: if start is reasserted after ready falls, the new pass begins with ready low.

## Test plan
- **Reference pass**
  - Stimulus: BRAM[i]=i for i=0..143; K=3, chn_num=107 (C=12), i2c_chn_sel=0, start held.
  - Reads: order 0,9,…,99,1,10,…,100,…,8,…,107.
  - Writes: wgt_out at wr_addr w = (w mod 12)·9 + ⌊w/12⌋; w=0→0, w=1→9, w=12→1, w=107→107.
  - Ready: rises at t0+111; chn_sel=0.
- **Handshake**
  - Drop start 3 cycles after ready → ready falls next cycle and state returns to IDLE.
  - Reassert start with i2c_chn_sel=1 → an identical pass with chn_sel=1.
- **Non-multiple length**
  - Stimulus: K=2, chn_num=9.
  - Reads: 0,4,8,1,5,9,2,6,3,7.
  - Writes: 10 writes to addr 0..9, then ready.
- **K=1**
  - Stimulus: K=1, chn_num=5.
  - Reads: 0..5 in order; wgt_out equals the identity copy.
- **Edge cases**
  - kernel_size=0 → no rd_en or wr_en; ready the cycle after start.
  - chn_num=0, K=3 → single read of addr 0 and single write to addr 0.
- **Reset mid-pass**: assert rst_n=0 during READ → all outputs 0 at once; after release, idle until start.

Source files
------------

// File: rtl/img2col_weight_core.sv
// img2col_weight_core: reorders a kernel's weights from channel-major BRAM
// order into kernel-position-major (img2col) order for the PE weight buffers.
module img2col_weight_core (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        i2c_wgt_start,
  input  logic        i2c_chn_sel,
  input  logic [6:0]  chn_num,
  input  logic [3:0]  kernel_size,
  input  logic [15:0] wgt_in,
  output logic        i2c_ready,
  output logic [7:0]  wgt_rd_addr,
  output logic        wgt_rd_en,
  output logic [7:0]  wgt_wr_addr,
  output logic        wgt_wr_en,
  output logic [15:0] wgt_out,
  output logic        chn_sel
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [6:0]  last_idx;
  logic [7:0]  kk;
  logic [7:0]  kk_calc;
  logic [7:0]  k_idx;
  logic [7:0]  addr;
  logic [7:0]  wr_addr;
  logic [8:0]  addr_step;
  logic [8:0]  k_step;
  logic        rd_vld;
  logic        start_pass;
  logic        step_addr;
  logic        step_k;

  assign wgt_rd_en   = (state == READ);
  assign i2c_ready   = (state == DONE);
  assign wgt_rd_addr = addr;
  assign wgt_wr_addr = wr_addr;

  // Address arithmetic: stride by K*K within a kernel position, else move to the next position
  always_comb begin
    kk_calc    = {4'd0, kernel_size} * {4'd0, kernel_size};
    addr_step  = {1'b0, addr} + {1'b0, kk};
    k_step     = {1'b0, k_idx} + 9'd1;
    start_pass = (state == IDLE) && i2c_wgt_start;
    step_addr  = (addr_step <= {2'b00, last_idx});
    step_k     = !step_addr && (k_step < {1'b0, kk}) && (k_step <= {2'b00, last_idx});
  end

  // State register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; DRAIN waits for the last read to reach the write stage
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (i2c_wgt_start) state_nxt = (kernel_size == 4'd0) ? DONE : READ;
      READ:  if (!step_addr && !step_k) state_nxt = DRAIN;
      DRAIN: if (!rd_vld) state_nxt = DONE;
      DONE:  if (!i2c_wgt_start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pass configuration and read address walker, reloaded only when a pass starts
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      last_idx <= 7'd0;
      kk       <= 8'd0;
      chn_sel  <= 1'b0;
      k_idx    <= 8'd0;
      addr     <= 8'd0;
    end else if (start_pass) begin
      last_idx <= chn_num;
      kk       <= kk_calc;
      chn_sel  <= i2c_chn_sel;
      k_idx    <= 8'd0;
      addr     <= 8'd0;
    end else if (state == READ) begin
      if (step_addr) begin
        addr <= addr_step[7:0];
      end else if (step_k) begin
        k_idx <= k_step[7:0];
        addr  <= k_step[7:0];
      end
    end
  end

  // Two-stage valid pipe matching the BRAM latency plus the output data register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld    <= 1'b0;
      wgt_wr_en <= 1'b0;
      wgt_out   <= 16'd0;
    end else begin
      rd_vld    <= wgt_rd_en;
      wgt_wr_en <= rd_vld;
      if (rd_vld) wgt_out <= wgt_in;
    end
  end

  // Sequential write address, restarting at zero for every pass
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)          wr_addr <= 8'd0;
    else if (start_pass) wr_addr <= 8'd0;
    else if (wgt_wr_en)  wr_addr <= wr_addr + 8'd1;
  end

endmodule

// File: tb/tb_img2col_weight_core.sv
// tb_img2col_weight_core: directed checks of read order, write stream,
// handshake, edge cases and asynchronous reset of img2col_weight_core.
module tb_img2col_weight_core;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        i2c_wgt_start;
  logic        i2c_chn_sel;
  logic [6:0]  chn_num;
  logic [3:0]  kernel_size;
  logic [15:0] wgt_in;
  logic        i2c_ready;
  logic [7:0]  wgt_rd_addr;
  logic        wgt_rd_en;
  logic [7:0]  wgt_wr_addr;
  logic        wgt_wr_en;
  logic [15:0] wgt_out;
  logic        chn_sel;

  logic [15:0] mem [256];
  int          vectors = 0;
  int          miscompares = 0;
  logic [23:0] rd_log [$];
  logic [39:0] wr_log [$];
  logic [7:0]  exp_rd [$];
  int          ready_cyc;

  img2col_weight_core dut (
    .clock         (clock),
    .rst_n         (rst_n),
    .i2c_wgt_start (i2c_wgt_start),
    .i2c_chn_sel   (i2c_chn_sel),
    .chn_num       (chn_num),
    .kernel_size   (kernel_size),
    .wgt_in        (wgt_in),
    .i2c_ready     (i2c_ready),
    .wgt_rd_addr   (wgt_rd_addr),
    .wgt_rd_en     (wgt_rd_en),
    .wgt_wr_addr   (wgt_wr_addr),
    .wgt_wr_en     (wgt_wr_en),
    .wgt_out       (wgt_out),
    .chn_sel       (chn_sel)
  );

  // Free-running clock
  always #5 clock = ~clock;

  // Weight BRAM model with one cycle of read latency
  always @(posedge clock) begin
    if (wgt_rd_en) wgt_in <= mem[wgt_rd_addr];
  end

  // Start a pass, log every read and write until ready, scrambling inputs mid-pass
  task automatic run_pass(input logic [3:0] k, input logic [6:0] n, input logic s, input int budget);
    @(negedge clock);
    kernel_size   = k;
    chn_num       = n;
    i2c_chn_sel   = s;
    i2c_wgt_start = 1'b1;
    rd_log.delete();
    wr_log.delete();
    ready_cyc = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clock);
      if (wgt_rd_en) rd_log.push_back({16'(c), wgt_rd_addr});
      if (wgt_wr_en) wr_log.push_back({16'(c), wgt_wr_addr, wgt_out});
      if (c == 2) begin
        kernel_size = ~k;
        chn_num     = ~n;
        i2c_chn_sel = ~s;
      end
      if (i2c_ready) begin
        ready_cyc = c;
        break;
      end
    end
  endtask

  // Drop start and let the core return to idle
  task automatic release_start;
    @(negedge clock);
    i2c_wgt_start = 1'b0;
    @(negedge clock);
  endtask

  // Channel-major to kernel-position-major read order
  function automatic void build_expected(input int kk, input int n);
    exp_rd.delete();
    for (int k = 0; k < kk && k <= n; k++)
      for (int a = k; a <= n; a += kk)
        exp_rd.push_back(8'(a));
  endfunction

  task automatic test_reset;
    rst_n         = 1'b0;
    i2c_wgt_start = 1'b0;
    i2c_chn_sel   = 1'b0;
    chn_num       = 7'd0;
    kernel_size   = 4'd0;
    #2;
    vectors++;
    if ({i2c_ready, wgt_rd_addr, wgt_rd_en, wgt_wr_addr, wgt_wr_en, wgt_out, chn_sel} !== 35'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs got %h required 0",
               {i2c_ready, wgt_rd_addr, wgt_rd_en, wgt_wr_addr, wgt_wr_en, wgt_out, chn_sel});
    end
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    repeat (3) @(negedge clock);
    vectors++;
    if ({i2c_ready, wgt_rd_en, wgt_wr_en} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_idle got ready/rd/wr=%b required 000", {i2c_ready, wgt_rd_en, wgt_wr_en});
    end
  endtask

  task automatic test_reference(input logic s);
    build_expected(9, 107);
    run_pass(4'd3, 7'd107, s, 200);
    vectors++;
    if (rd_log.size() != 108 || wr_log.size() != 108) begin
      miscompares++;
      $display("[TB] FAIL ref_len got rd=%0d wr=%0d required 108", rd_log.size(), wr_log.size());
    end
    for (int i = 0; i < 108; i++) begin
      vectors++;
      if (rd_log[i] !== {16'(i + 1), exp_rd[i]}) begin
        miscompares++;
        $display("[TB] FAIL ref_read[%0d] got cyc/addr %h required %h", i, rd_log[i], {16'(i + 1), exp_rd[i]});
      end
      vectors++;
      if (wr_log[i] !== {16'(i + 3), 8'(i), mem[exp_rd[i]]}) begin
        miscompares++;
        $display("[TB] FAIL ref_write[%0d] got cyc/addr/data %h required %h", i, wr_log[i],
                 {16'(i + 3), 8'(i), mem[exp_rd[i]]});
      end
    end
    vectors++;
    if (wr_log[1][15:0] !== 16'd9 || wr_log[12][15:0] !== 16'd1 || wr_log[107][15:0] !== 16'd107) begin
      miscompares++;
      $display("[TB] FAIL ref_spot got w1=%0d w12=%0d w107=%0d required 9 1 107",
               wr_log[1][15:0], wr_log[12][15:0], wr_log[107][15:0]);
    end
    vectors++;
    if (ready_cyc != 111 || chn_sel !== s) begin
      miscompares++;
      $display("[TB] FAIL ref_ready got cyc=%0d chn_sel=%b required 111 %b", ready_cyc, chn_sel, s);
    end
  endtask

  task automatic test_handshake;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock);
      vectors++;
      if (i2c_ready !== 1'b1 || wgt_rd_en !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL hold_ready[%0d] got ready=%b rd_en=%b required 1 0", i, i2c_ready, wgt_rd_en);
      end
    end
    i2c_wgt_start = 1'b0;
    @(negedge clock);
    vectors++;
    if (i2c_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ready_fall got %b required 0", i2c_ready);
    end
    @(negedge clock);
    vectors++;
    if (i2c_ready !== 1'b0 || wgt_rd_en !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL back_to_idle got ready=%b rd_en=%b required 0 0", i2c_ready, wgt_rd_en);
    end
    test_reference(1'b1);
    release_start();
  endtask

  task automatic test_non_multiple;
    exp_rd = '{8'd0, 8'd4, 8'd8, 8'd1, 8'd5, 8'd9, 8'd2, 8'd6, 8'd3, 8'd7};
    run_pass(4'd2, 7'd9, 1'b0, 40);
    vectors++;
    if (rd_log.size() != 10 || wr_log.size() != 10 || ready_cyc != 13) begin
      miscompares++;
      $display("[TB] FAIL nm_len got rd=%0d wr=%0d ready=%0d required 10 10 13",
               rd_log.size(), wr_log.size(), ready_cyc);
    end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (rd_log[i] !== {16'(i + 1), exp_rd[i]} || wr_log[i] !== {16'(i + 3), 8'(i), mem[exp_rd[i]]}) begin
        miscompares++;
        $display("[TB] FAIL nm_elem[%0d] got rd=%h wr=%h required rd=%h wr=%h", i, rd_log[i], wr_log[i],
                 {16'(i + 1), exp_rd[i]}, {16'(i + 3), 8'(i), mem[exp_rd[i]]});
      end
    end
    release_start();
  endtask

  task automatic test_k1;
    exp_rd = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    run_pass(4'd1, 7'd5, 1'b1, 30);
    vectors++;
    if (rd_log.size() != 6 || wr_log.size() != 6 || ready_cyc != 9 || chn_sel !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL k1_len got rd=%0d wr=%0d ready=%0d sel=%b required 6 6 9 1",
               rd_log.size(), wr_log.size(), ready_cyc, chn_sel);
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (rd_log[i] !== {16'(i + 1), exp_rd[i]} || wr_log[i] !== {16'(i + 3), 8'(i), 16'(i)}) begin
        miscompares++;
        $display("[TB] FAIL k1_elem[%0d] got rd=%h wr=%h required rd=%h wr=%h", i, rd_log[i], wr_log[i],
                 {16'(i + 1), exp_rd[i]}, {16'(i + 3), 8'(i), 16'(i)});
      end
    end
    release_start();
  endtask

  task automatic test_kernel_zero;
    run_pass(4'd0, 7'd20, 1'b0, 10);
    vectors++;
    if (rd_log.size() != 0 || wr_log.size() != 0 || ready_cyc != 1) begin
      miscompares++;
      $display("[TB] FAIL k0 got rd=%0d wr=%0d ready=%0d required 0 0 1", rd_log.size(), wr_log.size(), ready_cyc);
    end
    release_start();
  endtask

  task automatic test_single;
    run_pass(4'd3, 7'd0, 1'b0, 20);
    vectors++;
    if (rd_log.size() != 1 || wr_log.size() != 1 || ready_cyc != 4) begin
      miscompares++;
      $display("[TB] FAIL single_len got rd=%0d wr=%0d ready=%0d required 1 1 4",
               rd_log.size(), wr_log.size(), ready_cyc);
    end
    vectors++;
    if (rd_log[0] !== {16'd1, 8'd0} || wr_log[0] !== {16'd3, 8'd0, mem[0]}) begin
      miscompares++;
      $display("[TB] FAIL single_elem got rd=%h wr=%h required %h %h", rd_log[0], wr_log[0],
               {16'd1, 8'd0}, {16'd3, 8'd0, mem[0]});
    end
    release_start();
  endtask

  task automatic test_reset_mid;
    @(negedge clock);
    kernel_size   = 4'd3;
    chn_num       = 7'd107;
    i2c_chn_sel   = 1'b1;
    i2c_wgt_start = 1'b1;
    repeat (10) @(negedge clock);
    vectors++;
    if (wgt_rd_en !== 1'b1 || wgt_wr_en !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_active got rd=%b wr=%b required 1 1", wgt_rd_en, wgt_wr_en);
    end
    rst_n         = 1'b0;
    i2c_wgt_start = 1'b0;
    #1;
    vectors++;
    if ({i2c_ready, wgt_rd_addr, wgt_rd_en, wgt_wr_addr, wgt_wr_en, wgt_out, chn_sel} !== 35'd0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset got %h required 0",
               {i2c_ready, wgt_rd_addr, wgt_rd_en, wgt_wr_addr, wgt_wr_en, wgt_out, chn_sel});
    end
    @(negedge clock);
    rst_n = 1'b1;
    repeat (4) @(negedge clock);
    vectors++;
    if ({i2c_ready, wgt_rd_en, wgt_wr_en} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL post_reset_idle got ready/rd/wr=%b required 000", {i2c_ready, wgt_rd_en, wgt_wr_en});
    end
  endtask

  // Scenario sequence
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i);
    wgt_in = 16'd0;
    test_reset();
    test_reference(1'b0);
    test_handshake();
    test_non_multiple();
    test_k1();
    test_kernel_zero();
    test_single();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
